// File: rtl/dest_scoreboard.sv
// dest_scoreboard: issue-side destination scoreboard.
// Keeps a small pending-write counter for each of the 32 GPRs and 32 FPRs.
// Decoded instructions are held back while a source still has a write in
// flight (RAW), while the destination counter is full, or while the
// outstanding-write total is full. Counters drop as writebacks retire.
// GPR r0 is hard-wired, so it is never tracked and never reported busy.
module dest_scoreboard #(
  parameter int CNT_W   = 2,
  parameter int TOTAL_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               issue_valid,
  input  logic               issue_gen,
  input  logic               issue_flt,
  input  logic [4:0]         issue_reg_num,
  input  logic [2:0]         src_valid,
  input  logic [2:0]         src_flt,
  input  logic [2:0][4:0]    src_reg_num,
  output logic               issue_ready,
  input  logic               wb_valid,
  input  logic               wb_flt,
  input  logic [4:0]         wb_reg_num,
  output logic [TOTAL_W-1:0] busy_total,
  output logic               err_underflow
);

  localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [TOTAL_W-1:0] TOTAL_MAX = {TOTAL_W{1'b1}};

  // Registered per-register pending counters and their next values
  logic [CNT_W-1:0]   cnt_g     [32];
  logic [CNT_W-1:0]   cnt_f     [32];
  logic [CNT_W-1:0]   cnt_g_nxt [32];
  logic [CNT_W-1:0]   cnt_f_nxt [32];
  logic [TOTAL_W-1:0] busy_nxt;
  logic               err_nxt;

  // Destination decode
  logic               dest_g;
  logic               dest_f;
  logic               dest_trk;
  logic [CNT_W-1:0]   dest_cnt;

  // Hazard terms
  logic               raw;
  logic               sat;
  logic               full;

  // Issue / writeback qualification
  logic               accept;
  logic               accept_g;
  logic               accept_f;
  logic               wb_trk;
  logic [CNT_W-1:0]   wb_cnt;
  logic               retire_ok;
  logic               retire_err;

  // Saturating counter step: increment and decrement in the same cycle
  // cancel; the guards keep the counter from ever wrapping even if the
  // hazard logic upstream were bypassed.
  function automatic logic [CNT_W-1:0] cnt_step(
    input logic [CNT_W-1:0] cur,
    input logic             inc,
    input logic             dec
  );
    logic [CNT_W-1:0] res;
    res = cur;
    if (inc && !dec && (cur != CNT_MAX)) begin
      res = cur + 1'b1;
    end else if (dec && !inc && (cur != '0)) begin
      res = cur - 1'b1;
    end
    return res;
  endfunction

  // Same saturating step for the outstanding-write total.
  function automatic logic [TOTAL_W-1:0] total_step(
    input logic [TOTAL_W-1:0] cur,
    input logic               inc,
    input logic               dec
  );
    logic [TOTAL_W-1:0] res;
    res = cur;
    if (inc && !dec && (cur != TOTAL_MAX)) begin
      res = cur + 1'b1;
    end else if (dec && !inc && (cur != '0)) begin
      res = cur - 1'b1;
    end
    return res;
  endfunction

  // Destination decode: GPR wins when both flags are set; r0 is untracked
  always_comb begin
    dest_g   = issue_gen;
    dest_f   = issue_flt && !issue_gen;
    dest_trk = (dest_g && (issue_reg_num != 5'd0)) || dest_f;
    dest_cnt = '0;
    if (dest_g) begin
      dest_cnt = cnt_g[issue_reg_num];
    end else if (dest_f) begin
      dest_cnt = cnt_f[issue_reg_num];
    end
  end

  // RAW detection over the three source operands, from registered counts only
  always_comb begin
    raw = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (src_valid[i]) begin
        if (src_flt[i]) begin
          if (cnt_f[src_reg_num[i]] != '0) begin
            raw = 1'b1;
          end
        end else if (src_reg_num[i] != 5'd0) begin
          if (cnt_g[src_reg_num[i]] != '0) begin
            raw = 1'b1;
          end
        end
      end
    end
  end

  // Stall decision; deliberately independent of issue_valid and flush
  always_comb begin
    sat         = dest_trk && (dest_cnt == CNT_MAX);
    full        = (busy_total == TOTAL_MAX);
    issue_ready = !(raw || sat || full);
  end

  // Qualify the issue and writeback events that actually change state
  always_comb begin
    accept   = issue_valid && issue_ready && !flush;
    accept_g = accept && dest_trk && dest_g;
    accept_f = accept && dest_trk && dest_f;

    wb_trk   = wb_valid && !flush && (wb_flt || (wb_reg_num != 5'd0));
    wb_cnt   = wb_flt ? cnt_f[wb_reg_num] : cnt_g[wb_reg_num];
    retire_ok  = wb_trk && (wb_cnt != '0);
    retire_err = wb_trk && (wb_cnt == '0);
  end

  // Next-state for every counter; flush clears everything but the error flag
  always_comb begin
    for (int r = 0; r < 32; r++) begin
      if (flush) begin
        cnt_g_nxt[r] = '0;
        cnt_f_nxt[r] = '0;
      end else begin
        cnt_g_nxt[r] = cnt_step(cnt_g[r],
                                accept_g && (issue_reg_num == 5'(r)),
                                retire_ok && !wb_flt && (wb_reg_num == 5'(r)));
        cnt_f_nxt[r] = cnt_step(cnt_f[r],
                                accept_f && (issue_reg_num == 5'(r)),
                                retire_ok && wb_flt && (wb_reg_num == 5'(r)));
      end
    end

    if (flush) begin
      busy_nxt = '0;
    end else begin
      busy_nxt = total_step(busy_total, accept_g || accept_f, retire_ok);
    end

    err_nxt = err_underflow || retire_err;
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 32; r++) begin
        cnt_g[r] <= '0;
        cnt_f[r] <= '0;
      end
      busy_total    <= '0;
      err_underflow <= 1'b0;
    end else begin
      for (int r = 0; r < 32; r++) begin
        cnt_g[r] <= cnt_g_nxt[r];
        cnt_f[r] <= cnt_f_nxt[r];
      end
      busy_total    <= busy_nxt;
      err_underflow <= err_nxt;
    end
  end

endmodule

// File: tb/tb_dest_scoreboard.sv
// tb_dest_scoreboard: directed, table-driven bench for dest_scoreboard.
// Each table row is one clock cycle of inputs with the expected combinational
// issue_ready for that cycle and the expected registered outputs after the
// following rising edge. Hand-written sequences cover the total-full limit
// and asynchronous reset in the middle of activity.
module tb_dest_scoreboard;

  logic            clk;
  logic            rst_n;
  logic            flush;
  logic            issue_valid;
  logic            issue_gen;
  logic            issue_flt;
  logic [4:0]      issue_reg_num;
  logic [2:0]      src_valid;
  logic [2:0]      src_flt;
  logic [2:0][4:0] src_reg_num;
  logic            issue_ready;
  logic            wb_valid;
  logic            wb_flt;
  logic [4:0]      wb_reg_num;
  logic [5:0]      busy_total;
  logic            err_underflow;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       iv;
    logic       gen;
    logic       flt;
    logic [4:0] num;
    logic [2:0] sv;
    logic [2:0] sf;
    logic [4:0] s0;
    logic [4:0] s1;
    logic [4:0] s2;
    logic       wv;
    logic       wf;
    logic [4:0] wn;
    logic       fl;
    logic       rdy;
    logic [5:0] busy;
    logic       err;
  } vec_t;

  vec_t vq[$];

  dest_scoreboard #(.CNT_W(2), .TOTAL_W(6)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .issue_valid   (issue_valid),
    .issue_gen     (issue_gen),
    .issue_flt     (issue_flt),
    .issue_reg_num (issue_reg_num),
    .src_valid     (src_valid),
    .src_flt       (src_flt),
    .src_reg_num   (src_reg_num),
    .issue_ready   (issue_ready),
    .wb_valid      (wb_valid),
    .wb_flt        (wb_flt),
    .wb_reg_num    (wb_reg_num),
    .busy_total    (busy_total),
    .err_underflow (err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(
    input logic iv, input logic gen, input logic flt, input logic [4:0] num,
    input logic [2:0] sv, input logic [2:0] sf,
    input logic [4:0] s0, input logic [4:0] s1, input logic [4:0] s2,
    input logic wv, input logic wf, input logic [4:0] wn, input logic fl,
    input logic rdy, input logic [5:0] busy, input logic err
  );
    vec_t v;
    v.iv = iv;  v.gen = gen; v.flt = flt; v.num = num;
    v.sv = sv;  v.sf = sf;   v.s0 = s0;   v.s1 = s1;  v.s2 = s2;
    v.wv = wv;  v.wf = wf;   v.wn = wn;   v.fl = fl;
    v.rdy = rdy; v.busy = busy; v.err = err;
    vq.push_back(v);
  endfunction

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check6(input string name, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    flush         = 1'b0;
    issue_valid   = 1'b0;
    issue_gen     = 1'b0;
    issue_flt     = 1'b0;
    issue_reg_num = 5'd0;
    src_valid     = 3'b000;
    src_flt       = 3'b000;
    src_reg_num   = '0;
    wb_valid      = 1'b0;
    wb_flt        = 1'b0;
    wb_reg_num    = 5'd0;
  endtask

  initial begin
    // Row fields: iv gen flt num | sv sf s0 s1 s2 | wv wf wn | fl | rdy busy err
    add(0,0,0, 0, 3'b111,3'b000, 1, 2, 3, 0,0, 0, 0, 1,0,0); // reset state, all srcs valid
    add(1,1,0,21, 3'b000,3'b000, 0, 0, 0, 0,0, 0, 0, 1,1,0); // issue r21
    add(0,0,0, 0, 3'b001,3'b000,21, 0, 0, 0,0, 0, 0, 0,1,0); // src r21 busy
    add(0,0,0, 0, 3'b001,3'b000,21, 0, 0, 1,0,21, 0, 0,0,0); // wb r21, no bypass
    add(0,0,0, 0, 3'b001,3'b000,21, 0, 0, 0,0, 0, 0, 1,0,0); // r21 free again
    add(0,0,0, 0, 3'b000,3'b000, 0, 0, 0, 1,0, 0, 0, 1,0,0); // wb r0 ignored, no error
    add(1,0,1,24, 3'b000,3'b000, 0, 0, 0, 0,0, 0, 0, 1,1,0); // f24 #1
    add(1,0,1,24, 3'b000,3'b000, 0, 0, 0, 0,0, 0, 0, 1,2,0); // f24 #2
    add(1,0,1,24, 3'b000,3'b000, 0, 0, 0, 0,0, 0, 0, 1,3,0); // f24 #3
    add(1,0,1,24, 3'b000,3'b000, 0, 0, 0, 0,0, 0, 0, 0,3,0); // f24 #4 saturated
    add(0,0,0, 0, 3'b001,3'b000,24, 0, 0, 0,0, 0, 0, 1,3,0); // src GPR r24 unaffected
    add(0,0,0, 0, 3'b001,3'b001,24, 0, 0, 0,0, 0, 0, 0,3,0); // src FPR f24 busy
    add(1,1,1,24, 3'b000,3'b000, 0, 0, 0, 0,0, 0, 0, 1,4,0); // both flags -> GPR r24
    add(1,1,0, 0, 3'b111,3'b000, 0, 0, 0, 0,0, 0, 0, 1,4,0); // issue r0, src r0
    add(0,0,0, 0, 3'b000,3'b000, 0, 0, 0, 1,0,24, 0, 1,3,0); // wb GPR r24
    add(0,0,0, 0, 3'b000,3'b000, 0, 0, 0, 1,1,24, 0, 1,2,0); // wb f24
    add(0,0,0, 0, 3'b000,3'b000, 0, 0, 0, 1,1,24, 0, 1,1,0); // wb f24
    add(0,0,0, 0, 3'b000,3'b000, 0, 0, 0, 1,1,24, 0, 1,0,0); // wb f24
    add(1,1,0, 5, 3'b000,3'b000, 0, 0, 0, 0,0, 0, 0, 1,1,0); // issue r5
    add(1,1,0, 5, 3'b000,3'b000, 0, 0, 0, 1,0, 5, 0, 1,1,0); // issue+wb r5 same cycle
    add(0,0,0, 0, 3'b001,3'b000, 5, 0, 0, 0,0, 0, 0, 0,1,0); // r5 still pending
    add(0,0,0, 0, 3'b001,3'b000, 5, 0, 0, 1,0, 5, 0, 0,0,0); // wb r5
    add(0,0,0, 0, 3'b001,3'b000, 5, 0, 0, 0,0, 0, 0, 1,0,0); // r5 free
    add(0,0,0, 0, 3'b000,3'b000, 0, 0, 0, 1,1, 3, 0, 1,0,1); // wb f3 underflow
    add(1,1,0, 7, 3'b000,3'b000, 0, 0, 0, 0,0, 0, 0, 1,1,1); // issue r7
    add(1,0,1, 9, 3'b000,3'b000, 0, 0, 0, 1,0, 7, 0, 1,1,1); // issue f9, wb r7
    add(0,0,0, 0, 3'b011,3'b010, 7, 9, 0, 0,0, 0, 0, 0,1,1); // f9 busy, r7 free
    add(1,0,1, 2, 3'b000,3'b000, 0, 0, 0, 1,1, 9, 1, 1,0,1); // flush drops issue+wb
    add(0,0,0, 0, 3'b111,3'b110, 7, 9, 2, 0,0, 0, 0, 1,0,1); // all clear, err sticky

    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vq[k]) begin
      @(negedge clk);
      issue_valid    = vq[k].iv;
      issue_gen      = vq[k].gen;
      issue_flt      = vq[k].flt;
      issue_reg_num  = vq[k].num;
      src_valid      = vq[k].sv;
      src_flt        = vq[k].sf;
      src_reg_num    = {vq[k].s2, vq[k].s1, vq[k].s0};
      wb_valid       = vq[k].wv;
      wb_flt         = vq[k].wf;
      wb_reg_num     = vq[k].wn;
      flush          = vq[k].fl;
      #1;
      check1($sformatf("ready[%0d]", k), issue_ready, vq[k].rdy);
      @(posedge clk);
      #1;
      check6($sformatf("busy[%0d]", k), busy_total, vq[k].busy);
      check1($sformatf("err[%0d]", k), err_underflow, vq[k].err);
    end

    // Fill the total counter to its limit across r1..r31 (at most 3 each)
    for (int k = 0; k < 63; k++) begin
      @(negedge clk);
      idle_inputs();
      issue_valid   = 1'b1;
      issue_gen     = 1'b1;
      issue_reg_num = 5'((k % 31) + 1);
      #1;
      check1($sformatf("fill_ready[%0d]", k), issue_ready, 1'b1);
    end
    @(posedge clk);
    #1;
    check6("fill_busy", busy_total, 6'd63);

    // Total full: an FPR issue to a free register is still refused
    @(negedge clk);
    idle_inputs();
    issue_valid   = 1'b1;
    issue_flt     = 1'b1;
    issue_reg_num = 5'd0;
    #1;
    check1("full_ready", issue_ready, 1'b0);
    @(posedge clk);
    #1;
    check6("full_busy", busy_total, 6'd63);

    // One retirement frees a slot, visible the cycle after
    @(negedge clk);
    idle_inputs();
    wb_valid   = 1'b1;
    wb_reg_num = 5'd1;
    #1;
    check1("wb_full_ready", issue_ready, 1'b0);
    @(posedge clk);
    #1;
    check6("wb_full_busy", busy_total, 6'd62);
    @(negedge clk);
    idle_inputs();
    #1;
    check1("after_wb_ready", issue_ready, 1'b1);

    // Asynchronous reset mid-activity clears everything without a clock edge
    rst_n = 1'b0;
    #1;
    check6("async_rst_busy", busy_total, 6'd0);
    check1("async_rst_err", err_underflow, 1'b0);
    src_valid   = 3'b001;
    src_reg_num = {5'd0, 5'd0, 5'd2};
    #1;
    check1("async_rst_ready", issue_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    idle_inputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
